// File: rtl/seg_pkg.sv
// Shared definitions for the serial seven-segment driver: the FSM state
// encoding, the frame length and the hex-digit to segment-pattern table.
package seg_pkg;

    // Number of serial bits in one display frame (8 digits x 8 segments).
    localparam int FRAME_BITS = 64;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a} per hex digit; dp is off.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Look up the segment pattern for one hex digit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational decoder from one hex digit to its active-low segment byte.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    // Pure table lookup, no state.
    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg_serial_driver.sv
// Serialises a 32-bit word as eight seven-segment bytes to the board's
// display shift registers. A frame is: clear pulse (SEGCLR low), then 64 bits
// shifted MSB-first, digit7 first, each bit held for one SEGCLK low/high pair.
//
// Handshake: disp_vld is a request that is taken only in IDLE (busy=0 and no
// done pulse in that cycle); there is no ready output and nothing is queued,
// so a request raised while busy is simply dropped. done pulses for one cycle
// in the last busy cycle of a completed frame.
module seg_serial_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp_data,
    input  logic        disp_vld,
    output logic        busy,
    output logic        done,
    output logic        SEGCLK,
    output logic        SEGDT,
    output logic        SEGCLR,
    output logic        SEGEN,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] BIT_LAST = 7'(FRAME_BITS - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [6:0]  bit_cnt;
    logic [63:0] frame;
    logic [7:0]  seg [8];
    logic [63:0] frame_next;

    // One decoder per digit; digit g lives in disp_data[4g+3:4g].
    for (genvar g = 0; g < 8; g++) begin : g_dec
        hex_to_seg7 u_hex (
            .hex (disp_data[4*g +: 4]),
            .seg (seg[g])
        );
    end

    // Digit7 byte occupies the top of the frame so it leaves first.
    assign frame_next = {seg[7], seg[6], seg[5], seg[4],
                         seg[3], seg[2], seg[1], seg[0]};

    assign dbg_state = state;

    // Transfer FSM with registered serial outputs and separate divider/bit counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            SEGCLK  <= 1'b0;
            SEGDT   <= 1'b0;
            SEGCLR  <= 1'b1;
            SEGEN   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (disp_vld) begin
                        frame   <= frame_next;
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        SEGCLR  <= 1'b0;
                        SEGCLK  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (div_cnt == DIV_LAST) begin
                        // Clear pulse over; present the first bit on a low SEGCLK.
                        state   <= ST_SHIFT;
                        div_cnt <= '0;
                        SEGCLR  <= 1'b1;
                        SEGDT   <= frame[63];
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!SEGCLK) begin
                            // Data has been stable for a full low phase: rising edge.
                            SEGCLK <= 1'b1;
                        end else if (bit_cnt == BIT_LAST) begin
                            SEGCLK <= 1'b0;
                            state  <= ST_FINISH;
                            done   <= 1'b1;
                            SEGEN  <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit while SEGCLK is low.
                            SEGCLK  <= 1'b0;
                            SEGDT   <= frame[62];
                            frame   <= {frame[62:0], 1'b0};
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: one instance at CLK_DIV=2 for the
// main scenarios and one at CLK_DIV=1 for the fastest divider setting.
module tb_seg_serial_driver;

    logic        clk;
    logic        rst_n;
    logic [31:0] disp_data;
    logic        disp_vld;
    logic        disp_vld1;

    logic       busy, done, segclk, segdt, segclr, segen;
    logic [1:0] dbg;
    logic       busy1, done1, segclk1, segdt1, segclr1, segen1;
    logic [1:0] dbg1;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_serial_driver #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .disp_vld(disp_vld),
        .busy(busy), .done(done), .SEGCLK(segclk), .SEGDT(segdt),
        .SEGCLR(segclr), .SEGEN(segen), .dbg_state(dbg)
    );

    seg_serial_driver #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .disp_data(disp_data), .disp_vld(disp_vld1),
        .busy(busy1), .done(done1), .SEGCLK(segclk1), .SEGDT(segdt1),
        .SEGCLR(segclr1), .SEGEN(segen1), .dbg_state(dbg1)
    );

    // ---------------- monitors ----------------
    int          cyc = 0;
    logic        mon_clr = 1'b0;
    int          edges = 0, done_cnt = 0, done_cyc = 0, clr_low = 0, viol = 0;
    logic [63:0] cap = '0;
    logic        segclk_q = 1'b0, segdt_q = 1'b0;
    int          edges1 = 0, done_cnt1 = 0, done_cyc1 = 0;
    logic [63:0] cap1 = '0;
    logic        segclk1_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample the serial bus mid-cycle; a rising SEGCLK captures SEGDT.
    always @(negedge clk) begin
        segclk_q <= segclk;
        segdt_q  <= segdt;
        if (segclk && segclk_q && (segdt !== segdt_q)) viol <= viol + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (mon_clr) begin
            edges   <= 0;
            clr_low <= 0;
        end else begin
            if (segclk && !segclk_q) begin
                edges <= edges + 1;
                cap   <= {cap[62:0], segdt};
            end
            if (!segclr) clr_low <= clr_low + 1;
        end
    end

    always @(negedge clk) begin
        segclk1_q <= segclk1;
        if (segclk1 && !segclk1_q) begin
            edges1 <= edges1 + 1;
            cap1   <= {cap1[62:0], segdt1};
        end
        if (done1) begin
            done_cnt1 <= done_cnt1 + 1;
            done_cyc1 <= cyc;
        end
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;
    int acc_cyc1 = 0;

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    // Present a one-cycle request; the following posedge is the accept edge.
    task automatic start(input logic [31:0] data);
        @(negedge clk);
        disp_data = data;
        disp_vld  = 1'b1;
        acc_cyc   = cyc;
        @(negedge clk);
        disp_vld  = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string tag);
        int n;
        n = 0;
        while (done_cnt == prev && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != prev), 64'd1);
    endtask

    task automatic wait_edges(input int target);
        int n;
        n = 0;
        while (edges < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("edge_reached", 64'(edges >= target), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int prev;
        int gap;
        int n;
        logic [63:0] exp;

        rst_n     = 1'b0;
        disp_data = '0;
        disp_vld  = 1'b0;
        disp_vld1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_segclk", 64'(segclk), 64'd0);
        chk("rst_segdt",  64'(segdt),  64'd0);
        chk("rst_segclr", 64'(segclr), 64'd1);
        chk("rst_segen",  64'(segen),  64'd0);
        chk("rst_state",  64'(dbg),    64'd0);
        chk("rst1_segclr", 64'(segclr1), 64'd1);
        chk("rst1_state", 64'(dbg1),   64'd0);
        rst_n = 1'b1;

        // Expected frames, hand-encoded from the segment table
        exp_q.push_back(64'hC0C0C0C0C0C0C0C0); // 00000000
        exp_q.push_back(64'hF9A4B0998883C6A1); // 1234ABCD
        exp_q.push_back(64'h9286828EC0F88090); // 5E6F0789
        exp_q.push_back(64'hA18688A18386868E); // DEADBEEF
        exp_q.push_back(64'hC6C08E8E868699A4); // C0FFEE42

        // Frame of zeros: edges, bits, latency, clear length, enable
        clear_mon();
        prev = done_cnt;
        start(32'h00000000);
        @(negedge clk);
        chk("accept_busy", 64'(busy), 64'd1);
        chk("clear_segclr", 64'(segclr), 64'd0);
        wait_done(prev, "f0");
        exp = exp_q.pop_front();
        chk("f0_edges", 64'(edges), 64'd64);
        chk("f0_bits", cap, exp);
        chk("f0_latency", 64'(done_cyc - acc_cyc + 1), 64'd260);
        chk("f0_clr_low", 64'(clr_low), 64'd2);
        chk("f0_segen", 64'(segen), 64'd1);
        chk("f0_done_cnt", 64'(done_cnt - prev), 64'd1);
        @(negedge clk);
        chk("f0_idle_busy", 64'(busy), 64'd0);

        // 1234ABCD with an ignored all-ones request at bit 10 and data churn
        clear_mon();
        prev = done_cnt;
        start(32'h1234ABCD);
        wait_edges(10);
        @(negedge clk);
        disp_data = 32'hFFFFFFFF;
        disp_vld  = 1'b1;
        @(negedge clk);
        disp_vld  = 1'b0;
        wait_done(prev, "f1");
        exp = exp_q.pop_front();
        chk("f1_bits", cap, exp);
        chk("f1_edges", 64'(edges), 64'd64);
        repeat (20) @(negedge clk);
        chk("f1_single_done", 64'(done_cnt - prev), 64'd1);
        chk("f1_segen", 64'(segen), 64'd1);
        chk("f1_busy_after", 64'(busy), 64'd0);

        // Reset at bit 30 aborts without done; the next frame is complete
        clear_mon();
        prev = done_cnt;
        start(32'h1234ABCD);
        wait_edges(30);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",   64'(busy),   64'd0);
        chk("mid_rst_done",   64'(done),   64'd0);
        chk("mid_rst_segclk", 64'(segclk), 64'd0);
        chk("mid_rst_segdt",  64'(segdt),  64'd0);
        chk("mid_rst_segclr", 64'(segclr), 64'd1);
        chk("mid_rst_segen",  64'(segen),  64'd0);
        chk("mid_rst_state",  64'(dbg),    64'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - prev), 64'd0);
        clear_mon();
        prev = done_cnt;
        start(32'h5E6F0789);
        wait_done(prev, "f2");
        exp = exp_q.pop_front();
        chk("f2_bits", cap, exp);
        chk("f2_edges", 64'(edges), 64'd64);
        chk("f2_clr_low", 64'(clr_low), 64'd2);
        chk("f2_latency", 64'(done_cyc - acc_cyc + 1), 64'd260);

        // Request held high: back-to-back frames with one idle cycle between
        clear_mon();
        prev = done_cnt;
        @(negedge clk);
        disp_data = 32'hDEADBEEF;
        disp_vld  = 1'b1;
        wait_done(prev, "b0");
        exp = exp_q.pop_front();
        chk("b0_bits", cap, exp);
        gap = 0;
        n = 0;
        @(negedge clk);
        while (!busy && n < 50) begin
            gap++;
            n++;
            @(negedge clk);
        end
        chk("b2b_gap", 64'(gap), 64'd1);
        wait_done(prev + 1, "b1");
        @(negedge clk);
        disp_vld = 1'b0;
        chk("b1_bits", cap, exp);
        chk("b2b_edges", 64'(edges), 64'd128);
        chk("b2b_clr_low", 64'(clr_low), 64'd4);
        repeat (20) @(negedge clk);
        chk("b2b_done_cnt", 64'(done_cnt - prev), 64'd2);
        chk("b2b_idle", 64'(busy), 64'd0);

        // Fastest divider on the second instance
        prev = done_cnt1;
        @(negedge clk);
        chk("d1_idle_busy", 64'(busy1), 64'd0);
        disp_data = 32'hC0FFEE42;
        disp_vld1 = 1'b1;
        acc_cyc1  = cyc;
        @(negedge clk);
        disp_vld1 = 1'b0;
        chk("d1_clear_segclr", 64'(segclr1), 64'd0);
        n = 0;
        while (done_cnt1 == prev && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("d1_done_seen", 64'(done_cnt1 != prev), 64'd1);
        exp = exp_q.pop_front();
        chk("d1_bits", cap1, exp);
        chk("d1_edges", 64'(edges1), 64'd64);
        chk("d1_latency", 64'(done_cyc1 - acc_cyc1 + 1), 64'd131);
        chk("d1_segen", 64'(segen1), 64'd1);

        // SEGDT never moved while SEGCLK was high on the main instance
        chk("segdt_stable", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
